// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the add/sub arbiter.
// Stage bundles carry operands and results between registers.
package addsub_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] SAT_MAX = 8'h7F;
    localparam logic [DATA_W-1:0] SAT_MIN = 8'h80;

    typedef logic port_id_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              sub;
        port_id_t          id;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic              ovf;
        port_id_t          id;
    } s2_t;

endpackage

// File: rtl/addsub_arbiter_sat.sv
// Combinational 8-bit signed add/subtract with saturation.
// Subtract is a + ~b + 1; cout is the raw 9th bit.
module sat_addsub8
    import addsub_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o,
    output logic              ovf_o
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] raw;
    logic              ovf;

    // Raw sum, overflow detect and clamp toward the operand sign
    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        {cout_o, raw} = {1'b0, a_i} + {1'b0, b_eff}
                      + {{DATA_W{1'b0}}, sub_i};
        ovf = (a_i[DATA_W-1] == b_eff[DATA_W-1])
            && (raw[DATA_W-1] != a_i[DATA_W-1]);
        ovf_o = ovf;
        if (ovf) begin
            sum_o = a_i[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_o = raw;
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-port round-robin front end for one shared saturating adder.
// Optional saturation counter: define ADDSUB_SATCNT_EN.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_sub,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_sub,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_sum,
    output logic       rsp_cout,
    output logic       rsp_ovf,
    output logic       rsp_id
`ifdef ADDSUB_SATCNT_EN
    ,
    output logic [7:0] sat_count
`endif
);

    s1_t      s1_q, s1_d;
    logic     s1_v_q, s1_v_d;
    s2_t      s2_q, s2_d;
    logic     rsp_v_q, rsp_v_d;
    port_id_t rr_q, rr_d;

    logic     s2_load;
    logic     s1_load;
    logic     any_v;
    port_id_t cand;
    logic     accept;
    s1_t      req_sel;

    logic [DATA_W-1:0] alu_sum;
    logic              alu_cout;
    logic              alu_ovf;

    sat_addsub8 u_alu (
        .a_i    (s1_q.a),
        .b_i    (s1_q.b),
        .sub_i  (s1_q.sub),
        .sum_o  (alu_sum),
        .cout_o (alu_cout),
        .ovf_o  (alu_ovf)
    );

    // Arbitration, handshakes and next state of both stages
    always_comb begin
        s2_load = !rsp_v_q || rsp_ready;
        s1_load = !s1_v_q || s2_load;
        any_v   = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            cand = rr_q;
        end else begin
            cand = req1_valid;
        end
        accept     = rst_n && s1_load && any_v;
        req0_ready = accept && (cand == 1'b0);
        req1_ready = accept && (cand == 1'b1);
        if (cand) begin
            req_sel = '{a: req1_a, b: req1_b,
                        sub: req1_sub, id: 1'b1};
        end else begin
            req_sel = '{a: req0_a, b: req0_b,
                        sub: req0_sub, id: 1'b0};
        end
        rr_d   = accept ? ~cand : rr_q;
        s1_v_d = s1_load ? accept : s1_v_q;
        s1_d   = (s1_load && accept) ? req_sel : s1_q;
        rsp_v_d = s2_load ? s1_v_q : rsp_v_q;
        if (s2_load && s1_v_q) begin
            s2_d = '{sum: alu_sum, cout: alu_cout,
                     ovf: alu_ovf, id: s1_q.id};
        end else begin
            s2_d = s2_q;
        end
    end

    // Pipeline registers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s1_v_q  <= 1'b0;
            s2_q    <= '0;
            rsp_v_q <= 1'b0;
            rr_q    <= RR_INIT;
        end else begin
            s1_q    <= s1_d;
            s1_v_q  <= s1_v_d;
            s2_q    <= s2_d;
            rsp_v_q <= rsp_v_d;
            rr_q    <= rr_d;
        end
    end

    assign rsp_valid = rsp_v_q;
    assign rsp_sum   = s2_q.sum;
    assign rsp_cout  = s2_q.cout;
    assign rsp_ovf   = s2_q.ovf;
    assign rsp_id    = s2_q.id;

`ifdef ADDSUB_SATCNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Count delivered saturated results, sticking at 255
    always_comb begin
        cnt_d = cnt_q;
        if (rsp_v_q && rsp_ready && s2_q.ovf && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Saturation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_count = cnt_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomised self-checking bench for addsub_arbiter.
// Reference keeps in-flight ops in a queue and computes results with integer math.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_sub = 1'b0, req1_sub = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_sum;
    logic       rsp_cout, rsp_ovf, rsp_id;
`ifdef ADDSUB_SATCNT_EN
    logic [7:0] sat_count;
`endif

    always #5 clk = ~clk;

    addsub_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf),
        .rsp_id     (rsp_id)
`ifdef ADDSUB_SATCNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       id;
    } op_t;

    op_t  q[$];
    bit   m_outv, m_s1v, m_rr;
    int   m_cnt;
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0] smp_sum;
    logic       smp_cout, smp_ovf, smp_id, smp_v, smp_r0, smp_r1;
    logic       acc0, acc1;

    // {sum, cout, ovf} from signed integer arithmetic
    function automatic logic [9:0] calc(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic sub);
        int sa, sb, r, u;
        logic [7:0] s;
        logic ov, co;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        ov = (r > 127) || (r < -128);
        if (r > 127)       s = 8'h7F;
        else if (r < -128) s = 8'h80;
        else               s = r[7:0];
        u  = int'(a) + (sub ? 256 - int'(b) : int'(b));
        co = (u >= 256);
        return {s, co, ov};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare, then advance the model at posedge
    task automatic cycle(input logic v0, input logic [7:0] a0,
                         input logic [7:0] b0, input logic s0,
                         input logic v1, input logic [7:0] a1,
                         input logic [7:0] b1, input logic s1,
                         input logic rdy,
                         output logic o_acc0, output logic o_acc1);
        logic [9:0] e;
        logic cand, s2l, s1l, er0, er1, fire, fire_ovf;
        op_t o;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        rsp_ready  = rdy;
        #1;
        s2l  = !m_outv || rdy;
        s1l  = !m_s1v || s2l;
        cand = (v0 && v1) ? m_rr : v1;
        er0  = v0 && s1l && !cand;
        er1  = v1 && s1l && cand;
        chk("req0_ready", int'(req0_ready), int'(er0));
        chk("req1_ready", int'(req1_ready), int'(er1));
        chk("rsp_valid", int'(rsp_valid), int'(m_outv));
        fire_ovf = 1'b0;
        if (m_outv) begin
            e = calc(q[0].a, q[0].b, q[0].sub);
            fire_ovf = e[0];
            chk("rsp_sum", int'(rsp_sum), int'(e[9:2]));
            chk("rsp_cout", int'(rsp_cout), int'(e[1]));
            chk("rsp_ovf", int'(rsp_ovf), int'(e[0]));
            chk("rsp_id", int'(rsp_id), int'(q[0].id));
        end
`ifdef ADDSUB_SATCNT_EN
        chk("sat_count", int'(sat_count), m_cnt);
`endif
        smp_sum = rsp_sum; smp_cout = rsp_cout; smp_ovf = rsp_ovf;
        smp_id = rsp_id; smp_v = rsp_valid;
        smp_r0 = req0_ready; smp_r1 = req1_ready;
        fire   = m_outv && rdy;
        o_acc0 = er0;
        o_acc1 = er1;
        @(posedge clk);
        if (fire) begin
            if (fire_ovf && m_cnt < 255) m_cnt++;
            void'(q.pop_front());
        end
        if (er0 || er1) begin
            o.a   = er0 ? a0 : a1;
            o.b   = er0 ? b0 : b1;
            o.sub = er0 ? s0 : s1;
            o.id  = er1;
            q.push_back(o);
            m_rr  = er0;
        end
        m_outv = s2l ? m_s1v : m_outv;
        m_s1v  = s1l ? (er0 || er1) : m_s1v;
    endtask

    task automatic idle(input logic rdy);
        cycle(0, 8'h0, 8'h0, 0, 0, 8'h0, 8'h0, 0, rdy, acc0, acc1);
    endtask

    // Reset with both valids high; model drops everything in flight
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("rst_req0_ready", int'(req0_ready), 0);
        chk("rst_req1_ready", int'(req1_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_sum", int'(rsp_sum), 0);
        chk("rst_rsp_flags", int'({rsp_cout, rsp_ovf, rsp_id}), 0);
`ifdef ADDSUB_SATCNT_EN
        chk("rst_sat_count", int'(sat_count), 0);
`endif
        q.delete();
        m_outv = 0; m_s1v = 0; m_rr = 0; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_hold_req0_ready", int'(req0_ready), 0);
        chk("rst_hold_req1_ready", int'(req1_ready), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] e;
        int na0, na1;
        logic pv0, pv1, ps0, ps1, rdy;
        logic [7:0] pa0, pb0, pa1, pb1;

        e = calc(8'h05, 8'h03, 1'b0);
        chk("model_5p3", int'(e), int'({8'h08, 1'b0, 1'b0}));
        e = calc(8'h70, 8'h20, 1'b0);
        chk("model_70p20", int'(e), int'({8'h7F, 1'b0, 1'b1}));
        e = calc(8'h80, 8'h01, 1'b1);
        chk("model_80m01", int'(e), int'({8'h80, 1'b1, 1'b1}));
        e = calc(8'h40, 8'h40, 1'b0);
        chk("model_40p40", int'(e), int'({8'h7F, 1'b0, 1'b1}));

        do_reset();

        // Both valid at release: port 0 wins, port 1 follows
        cycle(1, 8'h05, 8'h03, 0, 1, 8'h70, 8'h20, 0, 1, acc0, acc1);
        chk("first_grant_p0", int'({smp_r0, smp_r1}), 2);
        cycle(0, 8'h00, 8'h00, 0, 1, 8'h70, 8'h20, 0, 1, acc0, acc1);
        chk("second_grant_p1", int'(smp_r1), 1);
        idle(1);
        chk("add_valid", int'(smp_v), 1);
        chk("add_sum", int'(smp_sum), 8'h08);
        chk("add_flags", int'({smp_cout, smp_ovf, smp_id}), 0);
        idle(1);
        chk("satadd_sum", int'(smp_sum), 8'h7F);
        chk("satadd_flags", int'({smp_cout, smp_ovf, smp_id}), 3'b011);

        // Saturating subtract on port 1 alone
        cycle(0, 8'h00, 8'h00, 0, 1, 8'h80, 8'h01, 1, 1, acc0, acc1);
        idle(1);
        idle(1);
        chk("satsub_sum", int'(smp_sum), 8'h80);
        chk("satsub_flags", int'({smp_cout, smp_ovf, smp_id}), 3'b111);
        idle(1);

        // Fairness: both valid continuously
        na0 = 0; na1 = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 8'(i), 8'h11, 0, 1, 8'h22, 8'(i), 1, 1, acc0, acc1);
            na0 += int'(acc0);
            na1 += int'(acc1);
        end
        chk("fair_p0_count", na0, 5);
        chk("fair_p1_count", na1, 5);
        idle(1); idle(1); idle(1);

        // Backpressure from an empty pipeline
        na0 = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 8'h7F, 8'(i), 0, 1, 8'(i), 8'h90, 1, 0, acc0, acc1);
            na0 += int'(acc0) + int'(acc1);
        end
        chk("stall_inflight", na0, 2);
        chk("stall_readys", int'({smp_r0, smp_r1}), 0);
        chk("stall_rsp_valid", int'(smp_v), 1);
        idle(1); idle(1); idle(1);

`ifdef ADDSUB_SATCNT_EN
        do_reset();
        cycle(1, 8'h7F, 8'h01, 0, 0, 8'h0, 8'h0, 0, 1, acc0, acc1);
        cycle(1, 8'h80, 8'h01, 1, 0, 8'h0, 8'h0, 0, 1, acc0, acc1);
        cycle(1, 8'h40, 8'h40, 0, 0, 8'h0, 8'h0, 0, 1, acc0, acc1);
        cycle(1, 8'h05, 8'h03, 0, 0, 8'h0, 8'h0, 0, 1, acc0, acc1);
        idle(1); idle(1); idle(1);
        chk("satcnt_three", int'(sat_count), 3);
`endif

        // Random traffic with request hold and random backpressure
        pv0 = 0; pv1 = 0;
        pa0 = 0; pb0 = 0; pa1 = 0; pb1 = 0; ps0 = 0; ps1 = 0;
        for (int i = 0; i < 1200; i++) begin
            if (i == 700) begin
                do_reset();
                pv0 = 0; pv1 = 0;
            end
            if (!pv0) begin
                pv0 = ($urandom % 3) != 0;
                pa0 = 8'($urandom); pb0 = 8'($urandom);
                ps0 = 1'($urandom);
            end
            if (!pv1) begin
                pv1 = ($urandom % 3) != 0;
                pa1 = 8'($urandom); pb1 = 8'($urandom);
                ps1 = 1'($urandom);
            end
            rdy = ($urandom % 4) != 0;
            cycle(pv0, pa0, pb0, ps0, pv1, pa1, pb1, ps1, rdy, acc0, acc1);
            if (acc0) pv0 = 0;
            if (acc1) pv1 = 0;
        end
        idle(1); idle(1); idle(1);
        chk("drain_empty", int'(rsp_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
